// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_t   : sequencer FSM states
//   cnt_width : bit width needed to hold 0..max_val (never less than 1)
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous status inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output, two cycles behind d_i
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, waits for lock with timeout and bounded
// retries, requires a stable-lock window, then releases the system reset.
//   clk        : free-running reference clock
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL lock flag, asynchronous to clk
//   restart    : single-cycle request to re-run the full sequence
//   pll_rst    : PLL reset, active high
//   sys_rst_n  : system reset, active low, deasserts synchronously
//   ready      : high while running
//   fault      : high once all lock attempts are exhausted
//   lock_lost  : sticky, lock dropped while running
//   retry_cnt  : failed lock attempts in the current sequence
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1024,
  parameter int unsigned LOCK_STABLE_CYCLES  = 16,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [cnt_width(MAX_RETRIES)-1:0]  retry_cnt
);

  localparam int unsigned RetryW    = cnt_width(MAX_RETRIES);
  localparam int unsigned TimerMax0 = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TimerMax  = ((TimerMax0 > LOCK_STABLE_CYCLES) ?
                                       TimerMax0 : LOCK_STABLE_CYCLES) - 1;
  localparam int unsigned TimerW    = cnt_width(TimerMax);

  localparam logic [TimerW-1:0] RstLast     = TimerW'(PLL_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  state_t              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                lock_lost_q, lock_lost_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic                locked_s;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (restart) begin
      state_d     = PLL_RST;
      timer_d     = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (timer_q == RstLast) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (locked_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            timer_d = '0;
            if (retry_q == RetryMax) begin
              state_d = FAULT;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + RetryW'(1);
            end
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        STABLE: begin
          // A dropout here is a glitch, not a failed attempt.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d = RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d     = PLL_RST;
            timer_d     = '0;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = PLL_RST;
          timer_d = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change with the state register.
    pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer. Expected output trajectories are
// derived per scenario from event times: reset pulse length, lock-to-ready latency
// (synchroniser + stable window), attempt period (pulse + timeout) and retry limit.
module tb_pll_reset_sequencer;

  localparam int PRC = 8;
  localparam int LTC = 32;
  localparam int LSC = 16;
  localparam int MR  = 3;
  localparam int P   = PRC + LTC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .MAX_RETRIES         (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  // Edge index cyc counts rising edges since reset release; values are sampled 1ns after.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Observation vector: {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt}
  task automatic test_reset();
    logic [6:0] exp, obs;
    rst_n      = 1'b0;
    pll_locked = 1'($urandom_range(0, 1));
    restart    = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", obs, exp);
    end
    restart    = 1'b0;
    pll_locked = 1'b0;
  endtask

  task automatic test_powerup(input int d0);
    logic [6:0] exp, obs;
    int s, r;
    do_reset();
    pll_locked = 1'b0;
    s = max2(PRC + 1, d0 + 3);
    r = s + LSC;
    while (cyc < r + 4) begin
      if (cyc == d0) pll_locked = 1'b1;
      tick();
      exp = {cyc < PRC, cyc >= r, cyc >= r, 1'b0, 1'b0, 2'd0};
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL powerup d0=%0d cyc=%0d got=%b want=%b", d0, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp, obs;
    int a;
    do_reset();
    pll_locked = 1'b0;
    while (cyc < (MR + 1) * P + 10) begin
      tick();
      a = cyc / P;
      if (a > MR) exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'(MR)};
      else        exp = {(cyc % P) < PRC, 1'b0, 1'b0, 1'b0, 1'b0, 2'(a)};
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%b want=%b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_glitch(input int g, input int w);
    logic [6:0] exp, obs;
    int d0, s, s2, r;
    do_reset();
    pll_locked = 1'b0;
    d0 = int'($urandom_range(0, 10));
    s  = max2(PRC + 1, d0 + 3);
    s2 = s + g + w + 3;
    r  = s2 + LSC;
    while (cyc < r + 3) begin
      if (cyc == d0)        pll_locked = 1'b1;
      if (cyc == s + g)     pll_locked = 1'b0;
      if (cyc == s + g + w) pll_locked = 1'b1;
      tick();
      exp = {cyc < PRC, cyc >= r, cyc >= r, 1'b0, 1'b0, 2'd0};
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL glitch g=%0d w=%0d cyc=%0d got=%b want=%b", g, w, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_run_loss(input int h, input int rr);
    logic [6:0] exp, obs;
    logic rdy;
    int d0, s, r, lo, s3, r3;
    do_reset();
    pll_locked = 1'b0;
    d0 = int'($urandom_range(0, 10));
    s  = max2(PRC + 1, d0 + 3);
    r  = s + LSC;
    lo = r + h + 3;
    s3 = max2(lo + PRC + 1, lo + rr + 3);
    r3 = s3 + LSC;
    while (cyc < r3 + 3) begin
      if (cyc == d0)      pll_locked = 1'b1;
      if (cyc == r + h)   pll_locked = 1'b0;
      if (cyc == lo + rr) pll_locked = 1'b1;
      tick();
      rdy = ((cyc >= r) && (cyc < lo)) || (cyc >= r3);
      exp = {(cyc < PRC) || ((cyc >= lo) && (cyc < lo + PRC)), rdy, rdy, 1'b0, cyc >= lo, 2'd0};
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL run_loss h=%0d rr=%0d cyc=%0d got=%b want=%b", h, rr, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_fault_restart(input int x, input int rr);
    logic [6:0] exp, obs;
    int d0, s, r, h, lo, f, q, s4, r4, rel, a;
    do_reset();
    pll_locked = 1'b0;
    d0 = int'($urandom_range(0, 10));
    s  = max2(PRC + 1, d0 + 3);
    r  = s + LSC;
    h  = int'($urandom_range(0, 5));
    lo = r + h + 3;
    f  = lo + (MR + 1) * P;
    q  = f + x + 1;
    s4 = max2(q + PRC + 1, q + rr + 3);
    r4 = s4 + LSC;
    while (cyc < r4 + 3) begin
      if (cyc == d0)     pll_locked = 1'b1;
      if (cyc == r + h)  pll_locked = 1'b0;
      if (cyc == f + x)  restart = 1'b1;
      if (cyc == q)      restart = 1'b0;
      if (cyc == q + rr) pll_locked = 1'b1;
      tick();
      if (cyc < lo) begin
        exp = {cyc < PRC, cyc >= r, cyc >= r, 1'b0, 1'b0, 2'd0};
      end else if (cyc < q) begin
        rel = cyc - lo;
        a   = rel / P;
        if (a > MR) exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'(MR)};
        else        exp = {(rel % P) < PRC, 1'b0, 1'b0, 1'b0, 1'b1, 2'(a)};
      end else begin
        exp = {(cyc - q) < PRC, cyc >= r4, cyc >= r4, 1'b0, 1'b0, 2'd0};
      end
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL fault_restart x=%0d rr=%0d cyc=%0d got=%b want=%b", x, rr, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_restart_pll_rst(input int k);
    logic [6:0] exp, obs;
    int q, r;
    do_reset();
    pll_locked = 1'b1;
    q = k + 1;
    r = q + PRC + 1 + LSC;
    while (cyc < r + 3) begin
      if (cyc == k) restart = 1'b1;
      if (cyc == q) restart = 1'b0;
      tick();
      exp = {cyc < q + PRC, cyc >= r, cyc >= r, 1'b0, 1'b0, 2'd0};
      obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL restart_pll_rst k=%0d cyc=%0d got=%b want=%b", k, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset(input bit in_run);
    logic [6:0] exp, obs;
    int r, stop;
    do_reset();
    pll_locked = 1'b1;
    r = PRC + 1 + LSC;
    stop = in_run ? r + int'($urandom_range(1, 10)) : PRC + 1 + int'($urandom_range(0, 14));
    for (int pass = 0; pass < 2; pass++) begin
      while (cyc < ((pass == 0) ? stop : r + 4)) begin
        tick();
        exp = {cyc < PRC, cyc >= r, cyc >= r, 1'b0, 1'b0, 2'd0};
        obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL async_rst run=%0d pass=%0d cyc=%0d got=%b want=%b",
                   in_run, pass, cyc, obs, exp);
        end
      end
      if (pass == 0) begin
        #3;
        rst_n = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        obs = {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL async_rst_assert run=%0d got=%b want=%b", in_run, obs, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup(20);
    test_powerup(int'($urandom_range(0, 30)));
    test_timeout();
    test_glitch(10, 1);
    test_glitch(int'($urandom_range(0, 12)), int'($urandom_range(1, 3)));
    test_run_loss(int'($urandom_range(0, 8)), int'($urandom_range(0, 20)));
    test_fault_restart(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
    test_restart_pll_rst(int'($urandom_range(0, 6)));
    test_async_reset(1'b0);
    test_async_reset(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
